// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch mode controller.
//  - FSM state encodings (also driven out on the mode port)
//  - display blank masks for the two adjust fields
//  - default debounce / synchroniser depths
package stopwatch_pkg;

    typedef logic [1:0] state_t;

    localparam state_t PAUSED  = 2'd0;
    localparam state_t RUN     = 2'd1;
    localparam state_t ADJ_MIN = 2'd2;
    localparam state_t ADJ_SEC = 2'd3;

    // bit0 = rightmost digit, 1 = digit off
    localparam logic [3:0] BLANK_MIN = 4'b1100;
    localparam logic [3:0] BLANK_SEC = 4'b0011;

    localparam int DEBOUNCE_CYC_DEF = 1_000_000;  // 10 ms at 100 MHz
    localparam int SYNC_STAGES_DEF  = 2;

    // Both adjust states share the upper encoding bit.
    function automatic logic is_adj(input state_t s);
        return s[1];
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_debounce.sv
// btn_debounce: synchroniser + stable-sample counter + press pulse.
//  clk, rst_n  board clock, async active-low reset
//  raw         raw pushbutton level (asynchronous)
//  press       one-cycle pulse when the debounced level goes 0->1
module btn_debounce #(
    parameter int DEBOUNCE_CYC = 1_000_000,
    parameter int SYNC_STAGES  = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic press
);
    localparam int CW = $clog2(DEBOUNCE_CYC + 1);

    logic [SYNC_STAGES-1:0] sync;
    logic [CW-1:0]          cnt;
    logic                   level;
    logic                   synced;

    assign synced = sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync <= '0;
        else        sync <= {sync[SYNC_STAGES-2:0], raw};
    end

    // cnt counts consecutive samples that differ from the accepted level.
    // It clears on any agreeing sample and on acceptance, so it is bounded
    // by DEBOUNCE_CYC-1 and cannot wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
        end else begin
            press <= 1'b0;
            if (synced == level) begin
                cnt <= '0;
            end else if (cnt >= CW'(DEBOUNCE_CYC - 1)) begin
                cnt   <= '0;
                level <= synced;
                press <= synced;  // only the 0->1 acceptance pulses
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: RUN/PAUSED/ADJUST mode controller for an MM:SS stopwatch.
//  clk, rst_n          board clock, async active-low reset
//  tick_1hz, tick_2hz  one-cycle timing enables
//  btn_pause, btn_rst  raw pushbuttons (debounced here)
//  sw_adj, sw_sel      raw switches (synchronised here)
//  cnt_en, cnt_clr, min_inc, sec_inc   registered one-cycle counter strobes
//  blank               per-digit blank mask for the display mux
//  mode                current FSM state
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
    parameter int SYNC_STAGES  = SYNC_STAGES_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1hz,
    input  logic       tick_2hz,
    input  logic       btn_pause,
    input  logic       btn_rst,
    input  logic       sw_adj,
    input  logic       sw_sel,
    output logic       cnt_en,
    output logic       cnt_clr,
    output logic       min_inc,
    output logic       sec_inc,
    output logic [3:0] blank,
    output logic [1:0] mode
);
    localparam int NUM_BTN = 2;

    logic [NUM_BTN-1:0] btn_raw, press;
    logic               pause_press, rst_press;

    assign btn_raw     = {btn_rst, btn_pause};
    assign pause_press = press[0];
    assign rst_press   = press[1];

    genvar g;
    generate
        for (g = 0; g < NUM_BTN; g++) begin : g_btn
            btn_debounce #(
                .DEBOUNCE_CYC(DEBOUNCE_CYC),
                .SYNC_STAGES (SYNC_STAGES)
            ) u_db (
                .clk  (clk),
                .rst_n(rst_n),
                .raw  (btn_raw[g]),
                .press(press[g])
            );
        end
    endgenerate

    // Switches: synchroniser only, index 0 = sw_adj, 1 = sw_sel.
    logic [1:0][SYNC_STAGES-1:0] sw_sync;
    logic                        adj_s, sel_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_sync <= '0;
        end else begin
            sw_sync[0] <= {sw_sync[0][SYNC_STAGES-2:0], sw_adj};
            sw_sync[1] <= {sw_sync[1][SYNC_STAGES-2:0], sw_sel};
        end
    end

    assign adj_s = sw_sync[0][SYNC_STAGES-1];
    assign sel_s = sw_sync[1][SYNC_STAGES-1];

    state_t     state, next_state;
    logic       phase, phase_d;
    logic       cnt_en_d, cnt_clr_d, min_inc_d, sec_inc_d;
    logic [3:0] blank_d;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= PAUSED;
        else        state <= next_state;
    end

    // Next state: the adjust switch overrides everything; pause presses
    // only matter in PAUSED/RUN, and leaving adjust always lands in PAUSED.
    always_comb begin
        next_state = state;
        if (adj_s) begin
            next_state = sel_s ? ADJ_SEC : ADJ_MIN;
        end else begin
            case (state)
                PAUSED:  if (pause_press) next_state = RUN;
                RUN:     if (pause_press) next_state = PAUSED;
                default: next_state = PAUSED;
            endcase
        end
    end

    // Outputs: strobes use the current state, so a tick arriving with a
    // pause press in RUN is still counted. A clear press masks all ticks.
    // blank is built from next_state/phase_d so it lines up with mode.
    always_comb begin
        cnt_clr_d = rst_press;
        cnt_en_d  = tick_1hz && (state == RUN)     && !rst_press;
        min_inc_d = tick_2hz && (state == ADJ_MIN) && !rst_press;
        sec_inc_d = tick_2hz && (state == ADJ_SEC) && !rst_press;

        phase_d = phase;
        if (!is_adj(next_state) || (next_state != state)) phase_d = 1'b0;
        else if (tick_2hz)                                 phase_d = ~phase;

        blank_d = 4'b0000;
        if (phase_d && next_state == ADJ_MIN)      blank_d = BLANK_MIN;
        else if (phase_d && next_state == ADJ_SEC) blank_d = BLANK_SEC;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_en  <= 1'b0;
            cnt_clr <= 1'b0;
            min_inc <= 1'b0;
            sec_inc <= 1'b0;
            blank   <= 4'b0000;
            phase   <= 1'b0;
        end else begin
            cnt_en  <= cnt_en_d;
            cnt_clr <= cnt_clr_d;
            min_inc <= min_inc_d;
            sec_inc <= sec_inc_d;
            blank   <= blank_d;
            phase   <= phase_d;
        end
    end

    assign mode = state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
module tb_stopwatch_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick_1hz = 1'b0, tick_2hz = 1'b0;
    logic       btn_pause = 1'b0, btn_rst = 1'b0;
    logic       sw_adj = 1'b0, sw_sel = 1'b0;
    logic       cnt_en, cnt_clr, min_inc, sec_inc;
    logic [3:0] blank;
    logic [1:0] mode;

    stopwatch_ctrl #(.DEBOUNCE_CYC(4), .SYNC_STAGES(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick_1hz (tick_1hz),
        .tick_2hz (tick_2hz),
        .btn_pause(btn_pause),
        .btn_rst  (btn_rst),
        .sw_adj   (sw_adj),
        .sw_sel   (sw_sel),
        .cnt_en   (cnt_en),
        .cnt_clr  (cnt_clr),
        .min_inc  (min_inc),
        .sec_inc  (sec_inc),
        .blank    (blank),
        .mode     (mode)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Observed output word: {cnt_en, cnt_clr, min_inc, sec_inc, blank, mode}
    logic [9:0] obs;
    assign obs = {cnt_en, cnt_clr, min_inc, sec_inc, blank, mode};

    function automatic logic [9:0] ev(input logic ce, input logic cc, input logic mi,
                                      input logic si, input logic [3:0] bl,
                                      input logic [1:0] md);
        return {ce, cc, mi, si, bl, md};
    endfunction

    task automatic chk(input string nm, input logic [9:0] act, input logic [9:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press_pause();
        btn_pause = 1'b1;
        step(8);
        btn_pause = 1'b0;
        step(10);
    endtask

    typedef struct {
        logic       t1;
        logic       t2;
        logic [9:0] exp;
        string      nm;
    } vec_t;

    vec_t tab[8];

    logic bounce_pat[24];
    int   toggles, n_clr, n_en;
    logic [1:0] prev_mode;

    initial begin
        // ADJ_MIN from phase 0: each tick_2hz gives min_inc and flips blank.
        tab[0] = '{1'b0, 1'b1, ev(0,0,1,0,4'b1100,2'd2), "adjmin_tick1"};
        tab[1] = '{1'b1, 1'b0, ev(0,0,0,0,4'b1100,2'd2), "adjmin_idle1"};
        tab[2] = '{1'b0, 1'b1, ev(0,0,1,0,4'b0000,2'd2), "adjmin_tick2"};
        tab[3] = '{1'b0, 1'b0, ev(0,0,0,0,4'b0000,2'd2), "adjmin_idle2"};
        tab[4] = '{1'b1, 1'b1, ev(0,0,1,0,4'b1100,2'd2), "adjmin_tick3"};
        tab[5] = '{1'b0, 1'b0, ev(0,0,0,0,4'b1100,2'd2), "adjmin_idle3"};
        tab[6] = '{1'b0, 1'b1, ev(0,0,1,0,4'b0000,2'd2), "adjmin_tick4"};
        tab[7] = '{1'b0, 1'b0, ev(0,0,0,0,4'b0000,2'd2), "adjmin_idle4"};

        // 1-0-1 bounce at 2-cycle spacing, stable high, then released
        for (int i = 0; i < 24; i++) bounce_pat[i] = (i < 14) && !(i == 2 || i == 3);

        // 1: reset state and quiet PAUSED with ticks running
        step(3);
        chk("reset_hold", obs, ev(0,0,0,0,4'b0000,2'd0));
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick_1hz = (i % 2 == 0);
            tick_2hz = (i % 3 == 0);
            step();
            chk("paused_quiet", obs, ev(0,0,0,0,4'b0000,2'd0));
        end
        tick_1hz = 1'b0;
        tick_2hz = 1'b0;
        step();

        // 2: pause press -> RUN, then three counted ticks
        press_pause();
        chk("enter_run", obs, ev(0,0,0,0,4'b0000,2'd1));
        for (int k = 0; k < 3; k++) begin
            tick_1hz = 1'b1;
            step();
            chk("cnt_en_pulse", obs, ev(1,0,0,0,4'b0000,2'd1));
            tick_1hz = 1'b0;
            for (int j = 0; j < 3; j++) begin
                step();
                chk("cnt_en_gap", obs, ev(0,0,0,0,4'b0000,2'd1));
            end
        end

        // 3: bouncing button yields a single toggle RUN -> PAUSED
        toggles   = 0;
        prev_mode = mode;
        for (int i = 0; i < 24; i++) begin
            btn_pause = bounce_pat[i];
            step();
            if (mode != prev_mode) toggles++;
            prev_mode = mode;
        end
        chk("bounce_toggles", 10'(toggles), 10'd1);
        chk("bounce_mode", obs, ev(0,0,0,0,4'b0000,2'd0));

        press_pause();
        chk("rerun", obs, ev(0,0,0,0,4'b0000,2'd1));

        // 4: clear press while ticks are present in RUN
        n_clr    = 0;
        n_en     = 0;
        btn_rst  = 1'b1;
        tick_1hz = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            n_clr += int'(cnt_clr);
            n_en  += int'(cnt_en);
            if (cnt_clr) chk("clr_masks_tick", obs, ev(0,1,0,0,4'b0000,2'd1));
        end
        chk("clr_count", 10'(n_clr), 10'd1);
        chk("tick_outside_clr", 10'(n_en), 10'd11);
        btn_rst  = 1'b0;
        tick_1hz = 1'b0;
        step(10);
        chk("run_after_clr", obs, ev(0,0,0,0,4'b0000,2'd1));

        // 5: adjust minutes via table, then switch field
        sw_adj = 1'b1;
        sw_sel = 1'b0;
        step(4);
        chk("enter_adjmin", obs, ev(0,0,0,0,4'b0000,2'd2));
        for (int i = 0; i < 8; i++) begin
            tick_1hz = tab[i].t1;
            tick_2hz = tab[i].t2;
            step();
            chk(tab[i].nm, obs, tab[i].exp);
        end
        tick_1hz = 1'b0;
        tick_2hz = 1'b1;
        step();
        chk("adjmin_phase1", obs, ev(0,0,1,0,4'b1100,2'd2));
        tick_2hz = 1'b0;
        sw_sel   = 1'b1;
        step(4);
        chk("sel_change_phase0", obs, ev(0,0,0,0,4'b0000,2'd3));
        tick_2hz = 1'b1;
        tick_1hz = 1'b1;
        step();
        chk("adjsec_tick", obs, ev(0,0,0,1,4'b0011,2'd3));
        tick_2hz = 1'b0;
        tick_1hz = 1'b0;
        step();
        chk("adjsec_hold", obs, ev(0,0,0,0,4'b0011,2'd3));
        press_pause();
        chk("pause_ignored_adj", obs, ev(0,0,0,0,4'b0011,2'd3));

        // 6: leave adjust -> PAUSED, then pause press -> RUN
        sw_adj = 1'b0;
        step(4);
        chk("exit_adj", obs, ev(0,0,0,0,4'b0000,2'd0));
        press_pause();
        chk("run_after_adj", obs, ev(0,0,0,0,4'b0000,2'd1));

        // asynchronous reset mid-operation, no strobe on release
        tick_1hz = 1'b1;
        rst_n    = 1'b0;
        #1;
        chk("async_reset_now", obs, ev(0,0,0,0,4'b0000,2'd0));
        step(2);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post_reset", obs, ev(0,0,0,0,4'b0000,2'd0));
        end
        tick_1hz = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
